// File: rtl/pof_stream_pkg.sv
// Shared types for the posit stream blocks: frame-assembly FSM states.
package pof_stream_pkg;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } stm_state_e;

endpackage

// File: rtl/stream_to_memory.sv
// Collects a stream of posit words into a frame bank and presents it as one unit.
// Optional macro STREAM_TO_MEMORY_ZERO_PAD_EN: clear unused bank entries at frame start.
module stream_to_memory
    import pof_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned MEMORY_DEPTH = 20
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  rts_i,
    output logic                                  rtr_o,
    input  logic                                  eow_i,
    input  logic [DATA_WIDTH-1:0]                 data_i,
    output logic                                  rts_o,
    input  logic                                  rtr_i,
    output logic                                  eow_o,
    output logic [DATA_WIDTH-1:0]                 data_o [MEMORY_DEPTH],
    output logic [$clog2(MEMORY_DEPTH+1)-1:0]     count_o
);

    localparam int unsigned WC_W  = $clog2(MEMORY_DEPTH);
    localparam int unsigned CNT_W = $clog2(MEMORY_DEPTH+1);

    stm_state_e       state_q;
    stm_state_e       state_d;
    logic [WC_W-1:0]  wc_q;

    logic             accept_c;
    logic             close_c;
    logic             release_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (close_c)   state_d = HOLD;
            HOLD:    if (release_c) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Handshake decode; the frame closes on the last slot or on an upstream tlast
    always_comb begin
        accept_c  = 1'b0;
        close_c   = 1'b0;
        release_c = 1'b0;
        accept_c  = rts_i & rtr_o;
        close_c   = accept_c & ((wc_q == WC_W'(MEMORY_DEPTH-1)) | eow_i);
        release_c = rts_o & rtr_i;
    end

    // Handshake flags, word counter and frame descriptors
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rtr_o   <= 1'b0;
            rts_o   <= 1'b0;
            eow_o   <= 1'b0;
            count_o <= '0;
            wc_q    <= '0;
        end else begin
            rtr_o <= (state_d == FILL);
            rts_o <= (state_d == HOLD);
            if (release_c) begin
                eow_o <= 1'b0;
            end
            if (close_c) begin
                eow_o   <= eow_i;
                count_o <= CNT_W'(wc_q) + CNT_W'(1);
                wc_q    <= '0;
            end else if (accept_c) begin
                wc_q <= wc_q + WC_W'(1);
            end
        end
    end

    // Word bank
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < MEMORY_DEPTH; k++) begin
                data_o[k] <= '0;
            end
        end else if (accept_c) begin
`ifdef STREAM_TO_MEMORY_ZERO_PAD_EN
            if (wc_q == '0) begin
                for (int unsigned k = 1; k < MEMORY_DEPTH; k++) begin
                    data_o[k] <= '0;
                end
            end
`endif
            data_o[wc_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_stream_to_memory.sv
// Directed self-checking bench for stream_to_memory (DATA_WIDTH=16, MEMORY_DEPTH=4).
module tb_stream_to_memory;

    localparam int unsigned DW = 16;
    localparam int unsigned MD = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          rts_i;
    logic          rtr_o;
    logic          eow_i;
    logic [DW-1:0] data_i;
    logic          rts_o;
    logic          rtr_i;
    logic          eow_o;
    logic [DW-1:0] data_o [MD];
    logic [2:0]    count_o;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_d [MD];

    stream_to_memory #(.DATA_WIDTH(DW), .MEMORY_DEPTH(MD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .rts_i  (rts_i),
        .rtr_o  (rtr_o),
        .eow_i  (eow_i),
        .data_i (data_i),
        .rts_o  (rts_o),
        .rtr_i  (rtr_i),
        .eow_o  (eow_o),
        .data_o (data_o),
        .count_o(count_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word for exactly one edge (caller ensures rtr_o=1)
    task automatic send(input logic [DW-1:0] d, input logic e);
        rts_i  = 1'b1;
        data_i = d;
        eow_i  = e;
        tick();
        rts_i = 1'b0;
        eow_i = 1'b0;
    endtask

    task automatic handshake();
        rtr_i = 1'b1;
        tick();
        rtr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (rtr_o !== 1'b0) begin errors++; $display("FAIL reset_rtr got %0b want 0", rtr_o); end
        checks++; if (rts_o !== 1'b0) begin errors++; $display("FAIL reset_rts got %0b want 0", rts_o); end
        checks++; if (eow_o !== 1'b0) begin errors++; $display("FAIL reset_eow got %0b want 0", eow_o); end
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count_o); end
        for (int k = 0; k < MD; k++) begin
            checks++;
            if (data_o[k] !== 16'h0) begin errors++; $display("FAIL reset_data[%0d] got %h want 0000", k, data_o[k]); end
        end
        rst_n = 1'b1;
        tick();
        checks++; if (rtr_o !== 1'b1) begin errors++; $display("FAIL reset_release_rtr got %0b want 1", rtr_o); end
    endtask

    task automatic test_full_frame();
        exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
        rts_i = 1'b1;
        for (int k = 0; k < MD; k++) begin
            data_i = exp_d[k];
            tick();
        end
        rts_i = 1'b0;
        checks++; if (rts_o !== 1'b1) begin errors++; $display("FAIL full_rts got %0b want 1", rts_o); end
        checks++; if (rtr_o !== 1'b0) begin errors++; $display("FAIL full_rtr got %0b want 0", rtr_o); end
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", count_o); end
        checks++; if (eow_o !== 1'b0) begin errors++; $display("FAIL full_eow got %0b want 0", eow_o); end
        for (int k = 0; k < MD; k++) begin
            checks++;
            if (data_o[k] !== exp_d[k]) begin errors++; $display("FAIL full_data[%0d] got %h want %h", k, data_o[k], exp_d[k]); end
        end
        handshake();
        checks++; if (rts_o !== 1'b0) begin errors++; $display("FAIL full_release_rts got %0b want 0", rts_o); end
        checks++; if (rtr_o !== 1'b1) begin errors++; $display("FAIL full_release_rtr got %0b want 1", rtr_o); end
    endtask

    task automatic test_early_eow();
        exp_d[0] = 16'hAAAA; exp_d[1] = 16'hBBBB;
`ifdef STREAM_TO_MEMORY_ZERO_PAD_EN
        exp_d[2] = 16'h0000; exp_d[3] = 16'h0000;
`else
        exp_d[2] = 16'h3333; exp_d[3] = 16'h4444;
`endif
        send(16'hAAAA, 1'b0);
        checks++; if (rts_o !== 1'b0) begin errors++; $display("FAIL early_rts_mid got %0b want 0", rts_o); end
        send(16'hBBBB, 1'b1);
        checks++; if (rts_o !== 1'b1) begin errors++; $display("FAIL early_rts got %0b want 1", rts_o); end
        checks++; if (count_o !== 3'd2) begin errors++; $display("FAIL early_count got %0d want 2", count_o); end
        checks++; if (eow_o !== 1'b1) begin errors++; $display("FAIL early_eow got %0b want 1", eow_o); end
        for (int k = 0; k < MD; k++) begin
            checks++;
            if (data_o[k] !== exp_d[k]) begin errors++; $display("FAIL early_data[%0d] got %h want %h", k, data_o[k], exp_d[k]); end
        end
        handshake();
        checks++; if (eow_o !== 1'b0) begin errors++; $display("FAIL early_release_eow got %0b want 0", eow_o); end
    endtask

    task automatic test_back_pressure();
        exp_d[0] = 16'h0101; exp_d[1] = 16'h0202; exp_d[2] = 16'h0303; exp_d[3] = 16'h0404;
        for (int k = 0; k < MD; k++) send(exp_d[k], 1'b0);
        rts_i  = 1'b1;
        data_i = 16'h5555;
        rtr_i  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (rts_o !== 1'b1 || rtr_o !== 1'b0 || count_o !== 3'd4 || data_o[0] !== 16'h0101 || data_o[3] !== 16'h0404)
            begin
                errors++;
                $display("FAIL bp_hold cyc %0d got rts=%0b rtr=%0b cnt=%0d d0=%h d3=%h want 1 0 4 0101 0404",
                         c, rts_o, rtr_o, count_o, data_o[0], data_o[3]);
            end
        end
        handshake();
        checks++; if (rts_o !== 1'b0) begin errors++; $display("FAIL bp_release_rts got %0b want 0", rts_o); end
        checks++; if (rtr_o !== 1'b1) begin errors++; $display("FAIL bp_release_rtr got %0b want 1", rtr_o); end
        tick();
        rts_i = 1'b0;
        checks++; if (data_o[0] !== 16'h5555) begin errors++; $display("FAIL bp_first_word got %h want 5555", data_o[0]); end
        checks++; if (data_o[1] === 16'h5555) begin errors++; $display("FAIL bp_single_accept got %h want not 5555", data_o[1]); end
    endtask

    task automatic test_reset_mid_fill();
        exp_d[0] = 16'h0A0A; exp_d[1] = 16'h0B0B; exp_d[2] = 16'h0C0C; exp_d[3] = 16'h0D0D;
        send(16'h0001, 1'b0);
        send(16'h0002, 1'b0);
        rst_n = 1'b0;
        tick();
        checks++; if (rtr_o !== 1'b0) begin errors++; $display("FAIL midrst_rtr got %0b want 0", rtr_o); end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < MD; k++) send(exp_d[k], 1'b0);
        checks++; if (rts_o !== 1'b1) begin errors++; $display("FAIL midrst_rts got %0b want 1", rts_o); end
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL midrst_count got %0d want 4", count_o); end
        for (int k = 0; k < MD; k++) begin
            checks++;
            if (data_o[k] !== exp_d[k]) begin errors++; $display("FAIL midrst_data[%0d] got %h want %h", k, data_o[k], exp_d[k]); end
        end
        handshake();
    endtask

    task automatic test_eow_full();
        for (int k = 0; k < MD; k++) send(16'h7000 + 16'(k), (k == MD-1));
        checks++; if (rts_o !== 1'b1) begin errors++; $display("FAIL eowfull_rts got %0b want 1", rts_o); end
        checks++; if (count_o !== 3'd4) begin errors++; $display("FAIL eowfull_count got %0d want 4", count_o); end
        checks++; if (eow_o !== 1'b1) begin errors++; $display("FAIL eowfull_eow got %0b want 1", eow_o); end
        checks++; if (data_o[3] !== 16'h7003) begin errors++; $display("FAIL eowfull_data3 got %h want 7003", data_o[3]); end
        handshake();
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (rts_o !== 1'b0 || rtr_o !== 1'b1 || eow_o !== 1'b0) begin
                errors++;
                $display("FAIL eowfull_idle cyc %0d got rts=%0b rtr=%0b eow=%0b want 0 1 0", c, rts_o, rtr_o, eow_o);
            end
            tick();
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        rts_i  = 1'b0;
        eow_i  = 1'b0;
        data_i = '0;
        rtr_i  = 1'b0;
        test_reset();
        test_full_frame();
        test_early_eow();
        test_back_pressure();
        test_reset_mid_fill();
        test_eow_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
